uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one UART transmitter.
// Requests are latched on grant and held until the UART takes them or times out.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [9*N_REQ-1:0]       i_data,
    output logic [N_REQ-1:0]         o_ack,
    output logic                     o_request_tx,
    output logic [8:0]               o_tx_data,
    input  logic                     i_tx_ready,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [7:0]     cnt;
    logic           found;
    logic [GW-1:0]  pick;
    logic           grant;
    logic           timeout_hit;
    int             idx;

    // Search starts one past the last grant and wraps around.
    always_comb begin
        found = 1'b0;
        pick  = o_grant_id;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = int'(o_grant_id) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && i_req[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_n     = state;
        grant       = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_tx_ready && found) begin
                    grant   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_tx_ready) begin
                    state_n = WAIT_DONE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = IDLE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    // Outputs are registered decodes of the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack        <= '0;
            o_request_tx <= 1'b0;
            o_tx_data    <= '0;
            o_grant_id   <= GW'(N_REQ - 1);
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
            cnt          <= '0;
        end else begin
            o_ack        <= grant ? (N_REQ'(1) << pick) : '0;
            o_request_tx <= (state_n == ISSUE);
            o_busy       <= (state_n != IDLE);
            o_timeout    <= timeout_hit;
            if (grant) begin
                o_tx_data  <= i_data[9*int'(pick) +: 9];
                o_grant_id <= pick;
                cnt        <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule
